// File: rtl/gf180mcu_osu_sc_12t_clk_pkg.sv
// Shared types and helpers for the registered clock divider.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package gf180mcu_osu_sc_12t_clk_pkg;

   // Phase of the divided clock; IDLE is the rest level between runs.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HI   = 2'd1,
      LO   = 2'd2
   } phase_e;

   // Smallest ratio that still yields one high and one low cycle.
   localparam int unsigned MIN_DIV = 2;

   // Ratios 0 and 1 cannot form a period, so they run as MIN_DIV.
   function automatic int unsigned clamp_div(input int unsigned d);
      return (d < MIN_DIV) ? MIN_DIV : d;
   endfunction

   // High phase takes the extra cycle of an odd ratio.
   function automatic int unsigned hi_len(input int unsigned d);
      return (d + 1) / 2;
   endfunction

   function automatic int unsigned lo_len(input int unsigned d);
      return d / 2;
   endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_12t_clkdiv_shadow.sv
// Shadow register for a requested ratio/polarity plus its pending flag.
// Latency: capture on the LD edge; pend visible one cycle later.
// Backpressure: none; a later LD overwrites an unapplied one.
module gf180mcu_osu_sc_12t_clkdiv_shadow
   import gf180mcu_osu_sc_12t_clk_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rn,
   input  logic             ld,
   input  logic [WIDTH-1:0] div,
   input  logic             inv,
   input  logic             apply,
   output logic [WIDTH-1:0] ld_div,
   output logic [WIDTH-1:0] sh_div,
   output logic             sh_inv,
   output logic             pend
);

   // Clamped request, also used directly by the top for bypass loads.
   assign ld_div = WIDTH'(clamp_div(32'(div)));

   // Capture on LD; pend drops whenever the owner applies the config.
   always_ff @(posedge clk) begin
      if (!rn) begin
         sh_div <= '0;
         sh_inv <= 1'b0;
         pend   <= 1'b0;
      end else begin
         if (ld) begin
            sh_div <= ld_div;
            sh_inv <= inv;
         end
         if (apply)   pend <= 1'b0;
         else if (ld) pend <= 1'b1;
      end
   end

endmodule

// File: rtl/gf180mcu_osu_sc_12t_clkdivinv.sv
// Registered clock divider: Y = CLK/div with optional inversion, glitch-free reprogramming.
// Latency: EN to first Y edge 1 cycle; LD takes effect at the next period boundary.
// Backpressure: none; loads during a period wait in the shadow (PEND), last write wins.
module gf180mcu_osu_sc_12t_clkdivinv
   import gf180mcu_osu_sc_12t_clk_pkg::*;
#(
   parameter int          WIDTH       = 8,
   parameter int unsigned DEFAULT_DIV = 2,
   parameter bit          DEFAULT_INV = 1'b0
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             EN,
   input  logic             LD,
   input  logic [WIDTH-1:0] DIV,
   input  logic             INV,
   output logic             Y,
   output logic             TICK,
   output logic             PEND
);

   phase_e           state, state_nx;
   logic [WIDTH-1:0] cnt, cnt_nx;
   logic [WIDTH-1:0] div_act, div_nx;
   logic             inv_act, inv_nx;
   logic             y_q, y_nx;
   logic             tick_q, tick_nx;
   logic             boundary;
   logic [WIDTH-1:0] cfg_div;
   logic             cfg_inv;
   logic [WIDTH-1:0] ld_div, sh_div;
   logic             sh_inv, pend;

   gf180mcu_osu_sc_12t_clkdiv_shadow #(.WIDTH(WIDTH)) u_shadow (
      .clk    (CLK),
      .rn     (RN),
      .ld     (LD),
      .div    (DIV),
      .inv    (INV),
      .apply  (boundary),
      .ld_div (ld_div),
      .sh_div (sh_div),
      .sh_inv (sh_inv),
      .pend   (pend)
   );

   // Next phase, counter and outputs; config only changes on a period boundary.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      div_nx   = div_act;
      inv_nx   = inv_act;
      y_nx     = y_q;
      tick_nx  = 1'b0;
      // An unknown encoding is treated as a boundary so the block recovers.
      boundary = (state == LO) ? (cnt == '0) : (state != HI);
      // A load on the boundary edge bypasses the shadow.
      cfg_div  = div_act;
      cfg_inv  = inv_act;
      if (LD) begin
         cfg_div = ld_div;
         cfg_inv = INV;
      end else if (pend) begin
         cfg_div = sh_div;
         cfg_inv = sh_inv;
      end
      if (state == HI) begin
         if (cnt == '0) begin
            state_nx = LO;
            cnt_nx   = WIDTH'(lo_len(32'(div_act)) - 1);
            y_nx     = inv_act;
         end else begin
            cnt_nx = cnt - WIDTH'(1);
         end
      end else if (boundary) begin
         div_nx = cfg_div;
         inv_nx = cfg_inv;
         if (EN) begin
            state_nx = HI;
            cnt_nx   = WIDTH'(hi_len(32'(cfg_div)) - 1);
            y_nx     = ~cfg_inv;
            tick_nx  = 1'b1;
         end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
            y_nx     = cfg_inv;
         end
      end else begin
         cnt_nx = cnt - WIDTH'(1);
      end
   end

   // State register; synchronous reset wins over EN and LD.
   always_ff @(posedge CLK) begin
      if (!RN) begin
         state   <= IDLE;
         cnt     <= '0;
         div_act <= WIDTH'(DEFAULT_DIV);
         inv_act <= DEFAULT_INV;
         y_q     <= DEFAULT_INV;
         tick_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         div_act <= div_nx;
         inv_act <= inv_nx;
         y_q     <= y_nx;
         tick_q  <= tick_nx;
      end
   end

   assign Y    = y_q;
   assign TICK = tick_q;
   assign PEND = pend;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkdivinv.sv
// Scoreboard bench for the clock divider: a period-position model predicts Y/TICK/PEND.
// Latency: expectation pushed at the driving negedge, checked 1 time unit after the next posedge.
// Backpressure: n/a.
module tb_gf180mcu_osu_sc_12t_clkdivinv;

   logic       CLK = 1'b0;
   logic       RN  = 1'b0;
   logic       EN  = 1'b0;
   logic       LD  = 1'b0;
   logic [7:0] DIV = 8'd0;
   logic       INV = 1'b0;
   logic       Y, TICK, PEND;

   gf180mcu_osu_sc_12t_clkdivinv #(.WIDTH(8), .DEFAULT_DIV(2), .DEFAULT_INV(1'b0)) dut (
      .CLK (CLK),
      .RN  (RN),
      .EN  (EN),
      .LD  (LD),
      .DIV (DIV),
      .INV (INV),
      .Y   (Y),
      .TICK(TICK),
      .PEND(PEND)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   // Expected {Y, TICK, PEND} per cycle, with a label for reporting.
   logic [2:0] exp_q[$];
   string      tag_q[$];
   string      phase = "reset";

   // Model: position inside the running period, active and shadow configs.
   bit m_run = 0;
   int m_pos = 0;
   int m_div = 2;
   bit m_inv = 0;
   bit m_pend = 0;
   int m_sh_div = 0;
   bit m_sh_inv = 0;

   task automatic model_step(input bit rn, input bit en, input bit ld, input int div, input bit inv);
      int c;
      c = (div < 2) ? 2 : div;
      if (!rn) begin
         m_run = 0; m_pos = 0; m_div = 2; m_inv = 0;
         m_pend = 0; m_sh_div = 0; m_sh_inv = 0;
      end else if (!m_run || m_pos == m_div - 1) begin
         if (ld) begin
            m_div = c; m_inv = inv;
         end else if (m_pend) begin
            m_div = m_sh_div; m_inv = m_sh_inv;
         end
         m_pend = 0;
         m_run  = en;
         m_pos  = 0;
      end else begin
         m_pos++;
         if (ld) begin
            m_sh_div = c; m_sh_inv = inv; m_pend = 1;
         end
      end
   endtask

   task automatic cyc(input bit rn, input bit en, input bit ld, input int div, input bit inv);
      bit ey, et;
      @(negedge CLK);
      RN = rn; EN = en; LD = ld; DIV = 8'(div); INV = inv;
      model_step(rn, en, ld, div & 255, inv);
      ey = m_run ? ((m_pos < (m_div + 1) / 2) ^ m_inv) : m_inv;
      et = m_run && (m_pos == 0);
      exp_q.push_back({ey, et, m_pend});
      tag_q.push_back(phase);
   endtask

   // Monitor: every cycle with an outstanding expectation is compared.
   initial begin
      logic [2:0] e;
      string      t;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if ({Y, TICK, PEND} !== e) begin
               failures++;
               $display("FAIL %s t=%0t got Y/TICK/PEND=%b%b%b expected %b%b%b",
                        t, $time, Y, TICK, PEND, e[2], e[1], e[0]);
            end
         end
      end
   end

   // Advance (EN held) until the next edge is the one closing a period.
   task automatic run_to_boundary(input bit en);
      for (int k = 0; k < 300 && !(m_run && m_pos == m_div - 1); k++) cyc(1, en, 0, 0, 0);
   endtask

   initial begin
      phase = "reset";
      repeat (3) cyc(0, 0, 0, 0, 0);
      phase = "reset_en_ld";
      repeat (3) cyc(0, 1, 1, 7, 1);

      phase = "div4";
      cyc(1, 0, 1, 4, 0);
      repeat (13) cyc(1, 1, 0, 0, 0);

      phase = "div5_inv";
      cyc(1, 1, 1, 5, 1);
      repeat (16) cyc(1, 1, 0, 0, 0);

      phase = "div4_to_6_midhi";
      cyc(1, 1, 1, 4, 0);
      run_to_boundary(1);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 1, 6, 0);
      repeat (14) cyc(1, 1, 0, 0, 0);

      phase = "ld_on_boundary";
      run_to_boundary(1);
      cyc(1, 1, 1, 3, 0);
      repeat (8) cyc(1, 1, 0, 0, 0);

      phase = "en_drop_div8";
      cyc(1, 1, 1, 8, 0);
      run_to_boundary(1);
      cyc(1, 1, 0, 0, 0);
      repeat (12) cyc(1, 0, 0, 0, 0);

      phase = "div0_clamp";
      cyc(1, 0, 1, 0, 0);
      repeat (6) cyc(1, 1, 0, 0, 0);
      phase = "div1_clamp";
      cyc(1, 1, 1, 1, 1);
      repeat (6) cyc(1, 1, 0, 0, 0);

      phase = "reset_pend_lo";
      cyc(1, 1, 1, 7, 0);
      run_to_boundary(1);
      repeat (5) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 1, 6, 1);
      cyc(1, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      repeat (8) cyc(1, 1, 0, 0, 0);

      phase = "random";
      begin
         bit en_r = 1;
         for (int i = 0; i < 3000; i++) begin
            int  d;
            bit  rn_r, ld_r;
            if ($urandom_range(0, 19) == 0) en_r = ~en_r;
            rn_r = ($urandom_range(0, 149) != 0);
            ld_r = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 8));
            cyc(rn_r, en_r, ld_r, d, 1'($urandom_range(0, 1)));
         end
      end

      @(negedge CLK);
      LD = 0;
      repeat (2) @(posedge CLK);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
